// File: rtl/fault_scan_sequencer.sv
// Stuck-at scan sequencer: LFSR patterns in, settle, compare CUT vs golden, log first failure and count.
// Optional build macro STOP_ON_FAIL_EN ends the run at the first mismatching pattern.
module fault_scan_sequencer #(
  parameter int               VEC_W   = 4,
  parameter int               RSP_W   = 4,
  parameter int               NUM_VEC = 15,
  parameter int               IDX_W   = 4,
  parameter int               SETTLE  = 2,
  parameter logic [VEC_W-1:0] SEED    = 4'b0001,
  parameter logic [VEC_W-1:0] TAPS    = 4'b1001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RSP_W-1:0] rsp_dut,
  input  logic [RSP_W-1:0] rsp_gold,
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [IDX_W-1:0] fail_idx,
  output logic [7:0]       fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam int               CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
  logic [7:0]         fail_cnt_q, fail_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mismatch;
  logic               last_pattern;

  function automatic logic [VEC_W-1:0] lfsr_next(input logic [VEC_W-1:0] v);
    return {v[VEC_W-2:0], ^(v & TAPS)};
  endfunction

  assign mismatch = (rsp_dut != rsp_gold);

  // A run ends on the last index, or on the first mismatch when early stop is built in.
`ifdef STOP_ON_FAIL_EN
  assign last_pattern = (idx_q == LAST_IDX) || mismatch;
`else
  assign last_pattern = (idx_q == LAST_IDX);
`endif

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    fault_d    = fault_q;
    fail_idx_d = fail_idx_q;
    fail_cnt_d = fail_cnt_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d      = SEED;
          idx_d      = '0;
          fault_d    = 1'b0;
          fail_idx_d = '0;
          fail_cnt_d = '0;
          state_d    = S_APPLY;
        end
      end
      S_APPLY: begin
        cnt_d   = SETTLE_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_COMPARE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_COMPARE: begin
        if (mismatch) begin
          if (!fault_q) begin
            fail_idx_d = idx_q;
            fault_d    = 1'b1;
          end
          if (fail_cnt_q != 8'hFF) begin
            fail_cnt_d = fail_cnt_q + 8'd1;
          end
        end
        if (last_pattern) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          vec_d   = lfsr_next(vec_q);
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy/done are registered decodes of the upcoming state so they line up with it.
    busy_d = (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_COMPARE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      fail_idx_q <= '0;
      fail_cnt_q <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      fail_idx_q <= fail_idx_d;
      fail_cnt_q <= fail_cnt_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign vec_out  = vec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fault    = fault_q;
  assign fail_idx = fail_idx_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_fault_scan_sequencer.sv
// Testbench for fault_scan_sequencer: table-driven 4-pattern runs plus reset-abort and saturation sequences.
// Expectations for the STOP_ON_FAIL_EN build are selected with the same macro.
module tb_fault_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start_a = 1'b0;
  logic [3:0] rsp_dut_a = 4'hA;
  logic [3:0] rsp_gold_a = 4'hA;
  logic [3:0] vec_a;
  logic       busy_a, done_a, fault_a;
  logic [3:0] fidx_a;
  logic [7:0] cnt_a;

  logic       start_s = 1'b0;
  logic [3:0] rsp_dut_s = 4'h5;
  logic [3:0] rsp_gold_s = 4'hA;
  logic [3:0] vec_s;
  logic       busy_s, done_s, fault_s;
  logic [8:0] fidx_s;
  logic [7:0] cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fault_scan_sequencer #(.NUM_VEC(4), .SETTLE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rsp_dut(rsp_dut_a), .rsp_gold(rsp_gold_a),
    .vec_out(vec_a), .busy(busy_a), .done(done_a), .fault(fault_a),
    .fail_idx(fidx_a), .fail_cnt(cnt_a)
  );

  fault_scan_sequencer #(.IDX_W(9), .NUM_VEC(300), .SETTLE(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .rsp_dut(rsp_dut_s), .rsp_gold(rsp_gold_s),
    .vec_out(vec_s), .busy(busy_s), .done(done_s), .fault(fault_s),
    .fail_idx(fidx_s), .fail_cnt(cnt_s)
  );

  typedef struct {
    logic       first;
    logic       last;
    logic       mis;
    logic       pulse;
    logic [3:0] exp_vec;
    logic       exp_fault;
    logic [3:0] exp_fidx;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic first, input logic last, input logic mis, input logic pulse,
                              input logic [3:0] ev, input logic ef, input logic [3:0] ei,
                              input logic [7:0] ec);
    vec_t r;
    r.first = first; r.last = last; r.mis = mis; r.pulse = pulse;
    r.exp_vec = ev; r.exp_fault = ef; r.exp_fidx = ei; r.exp_cnt = ec;
    return r;
  endfunction

  task automatic applyStimulus(input logic st, input logic mis);
    start_a   = st;
    rsp_dut_a = mis ? 4'h5 : 4'hA;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  initial begin
    int busy_cycles;
    int waited;

    // Run 0: clean; run 1: mismatches; run 2: clean with stray start pulses.
    tbl.push_back(mk(1, 0, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0011, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0111, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, 0, 0));
`ifdef STOP_ON_FAIL_EN
    tbl.push_back(mk(1, 0, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4'b0011, 1, 1, 1));
`else
    tbl.push_back(mk(1, 0, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0011, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'b0111, 1, 2, 1));
    tbl.push_back(mk(0, 1, 1, 0, 4'b1111, 1, 2, 2));
`endif
    tbl.push_back(mk(1, 0, 0, 1, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'b0011, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'b0111, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, 0, 0));

    repeat (3) @(negedge clk);
    checkOutput("rst_vec_out", vec_a, 0);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_done", done_a, 0);
    checkOutput("rst_fault", fault_a, 0);
    checkOutput("rst_fail_idx", fidx_a, 0);
    checkOutput("rst_fail_cnt", cnt_a, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", busy_a, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].first) begin
        applyStimulus(1'b1, tbl[i].mis);
        @(negedge clk);
        checkOutput($sformatf("start_clr_fault[%0d]", i), fault_a, 0);
        checkOutput($sformatf("start_clr_fail_idx[%0d]", i), fidx_a, 0);
        checkOutput($sformatf("start_clr_fail_cnt[%0d]", i), cnt_a, 0);
      end
      for (int c = 0; c < 4; c++) begin
        applyStimulus(tbl[i].pulse && (c == 1), tbl[i].mis);
        checkOutput($sformatf("vec_out[%0d.%0d]", i, c), vec_a, tbl[i].exp_vec);
        checkOutput($sformatf("busy[%0d.%0d]", i, c), busy_a, 1);
        checkOutput($sformatf("done_early[%0d.%0d]", i, c), done_a, 0);
        @(negedge clk);
      end
      applyStimulus(1'b0, tbl[i].mis);
      checkOutput($sformatf("fault[%0d]", i), fault_a, tbl[i].exp_fault);
      checkOutput($sformatf("fail_idx[%0d]", i), fidx_a, tbl[i].exp_fidx);
      checkOutput($sformatf("fail_cnt[%0d]", i), cnt_a, tbl[i].exp_cnt);
      if (tbl[i].last) begin
        checkOutput($sformatf("done_pulse[%0d]", i), done_a, 1);
        checkOutput($sformatf("busy_in_done[%0d]", i), busy_a, 0);
        checkOutput($sformatf("vec_hold_done[%0d]", i), vec_a, tbl[i].exp_vec);
        @(negedge clk);
        checkOutput($sformatf("done_one_cycle[%0d]", i), done_a, 0);
        checkOutput($sformatf("busy_after[%0d]", i), busy_a, 0);
        checkOutput($sformatf("fault_hold[%0d]", i), fault_a, tbl[i].exp_fault);
        checkOutput($sformatf("fail_cnt_hold[%0d]", i), cnt_a, tbl[i].exp_cnt);
        @(negedge clk);
        checkOutput($sformatf("no_second_done[%0d]", i), done_a, 0);
        checkOutput($sformatf("vec_hold_idle[%0d]", i), vec_a, tbl[i].exp_vec);
      end
    end

    // Abort mid-run on the saturation instance after it has logged a mismatch.
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_vec_out", vec_s, 0);
    checkOutput("abort_busy", busy_s, 0);
    checkOutput("abort_done", done_s, 0);
    checkOutput("abort_fault", fault_s, 0);
    checkOutput("abort_fail_cnt", cnt_s, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("abort_no_done[%0d]", k), done_s, 0);
      checkOutput($sformatf("abort_idle[%0d]", k), busy_s, 0);
      @(negedge clk);
    end

    // Every compare mismatches: the counter has to saturate.
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    busy_cycles = 0;
    waited = 0;
    while (!done_s && waited < 5000) begin
      if (busy_s) busy_cycles++;
      waited++;
      @(negedge clk);
    end
    checkOutput("sat_done_seen", done_s, 1);
`ifdef STOP_ON_FAIL_EN
    checkOutput("sat_busy_cycles", busy_cycles, 3);
    checkOutput("sat_fail_cnt", cnt_s, 1);
`else
    checkOutput("sat_busy_cycles", busy_cycles, 900);
    checkOutput("sat_fail_cnt", cnt_s, 255);
`endif
    checkOutput("sat_fail_idx", fidx_s, 0);
    checkOutput("sat_fault", fault_s, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
